// File: rtl/branch_resolve_unit_if.sv
// Request/result/prediction bundle between the issue stage, the branch
// resolve unit and the fetch predictor lookup.
interface branch_resolve_unit_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_kind;
   logic [2:0]      in_funct;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_src1;
   logic [XLEN-1:0] in_src2;
   logic [XLEN-1:0] in_imm;
   logic            in_pred_taken;
   logic [XLEN-1:0] in_pred_target;
   logic            out_valid;
   logic            out_ready;
   logic            out_taken;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_link;
   logic            out_mispredict;
   logic [XLEN-1:0] out_redirect_pc;
   logic [XLEN-1:0] pred_pc;
   logic            pred_taken;

   // Pipeline side: issues requests, consumes results, looks up predictions.
   modport master (
      output flush, in_valid, in_kind, in_funct, in_pc, in_src1, in_src2, in_imm,
             in_pred_taken, in_pred_target, out_ready, pred_pc,
      input  in_ready, out_valid, out_taken, out_target, out_link, out_mispredict,
             out_redirect_pc, pred_taken
   );

   // Resolve unit side.
   modport slave (
      input  flush, in_valid, in_kind, in_funct, in_pc, in_src1, in_src2, in_imm,
             in_pred_taken, in_pred_target, out_ready, pred_pc,
      output in_ready, out_valid, out_taken, out_target, out_link, out_mispredict,
             out_redirect_pc, pred_taken
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: evaluates conditional branches and
// jumps, compares against the fetch prediction, presents redirect info through
// a valid/ready output register, and trains a 2-bit saturating-counter BHT.
module branch_resolve_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64
) (
   input logic                  clk,
   input logic                  rst_n,
   branch_resolve_unit_if.slave bus
);
   localparam int IDX = $clog2(BHT_ENTRIES);

   typedef logic [XLEN-1:0] word_t;

   localparam logic [1:0] KIND_COND = 2'b00;
   localparam logic [1:0] KIND_JAL  = 2'b01;
   localparam logic [1:0] KIND_JALR = 2'b10;

   logic          taken_c;
   logic          legal_cond_c;
   word_t         target_c;
   word_t         link_c;
   logic          mispredict_c;
   logic          accept;

   logic          out_valid_q,  out_valid_d;
   logic          out_taken_q,  out_taken_d;
   word_t         out_target_q, out_target_d;
   word_t         out_link_q,   out_link_d;
   logic          out_mis_q,    out_mis_d;

   logic [1:0]    bht_q [BHT_ENTRIES];
   logic [IDX-1:0] bht_idx;
   logic [1:0]    bht_cur;
   logic [1:0]    bht_nxt;
   logic          bht_we;

   logic          unused_pred_bits;

   // Only the word-index bits of the lookup PC address the table.
   assign unused_pred_bits = ^{bus.pred_pc[XLEN-1:IDX+2], bus.pred_pc[1:0]};

   // Flush blocks acceptance outright, so it can never race with a load or a BHT write.
   assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   // Resolve direction, target, link and mispredict for the presented request.
   always_comb begin
      taken_c      = 1'b0;
      legal_cond_c = 1'b0;
      target_c     = '0;
      case (bus.in_kind)
         KIND_COND: begin
            target_c     = bus.in_pc + bus.in_imm;
            legal_cond_c = 1'b1;
            case (bus.in_funct)
               3'b000:  taken_c = (bus.in_src1 == bus.in_src2);
               3'b001:  taken_c = (bus.in_src1 != bus.in_src2);
               3'b100:  taken_c = ($signed(bus.in_src1) <  $signed(bus.in_src2));
               3'b101:  taken_c = ($signed(bus.in_src1) >= $signed(bus.in_src2));
               3'b110:  taken_c = (bus.in_src1 <  bus.in_src2);
               3'b111:  taken_c = (bus.in_src1 >= bus.in_src2);
               default: legal_cond_c = 1'b0;
            endcase
         end
         KIND_JAL: begin
            taken_c  = 1'b1;
            target_c = bus.in_pc + bus.in_imm;
         end
         KIND_JALR: begin
            taken_c  = 1'b1;
            target_c = (bus.in_src1 + bus.in_imm) & ~word_t'(1);
         end
         default: begin
            taken_c  = 1'b0;
            target_c = '0;
         end
      endcase
      link_c       = bus.in_pc + word_t'(4);
      mispredict_c = (taken_c != bus.in_pred_taken) ||
                     (taken_c && (target_c != bus.in_pred_target));
   end

   // Output register next state: flush kills, accept loads, handoff drains.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_taken_d  = out_taken_q;
      out_target_d = out_target_q;
      out_link_d   = out_link_q;
      out_mis_d    = out_mis_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d  = 1'b1;
         out_taken_d  = taken_c;
         out_target_d = target_c;
         out_link_d   = link_c;
         out_mis_d    = mispredict_c;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_taken_q  <= 1'b0;
         out_target_q <= '0;
         out_link_q   <= '0;
         out_mis_q    <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_taken_q  <= out_taken_d;
         out_target_q <= out_target_d;
         out_link_q   <= out_link_d;
         out_mis_q    <= out_mis_d;
      end
   end

   assign bus.out_valid       = out_valid_q;
   assign bus.out_taken       = out_taken_q;
   assign bus.out_target      = out_target_q;
   assign bus.out_link        = out_link_q;
   assign bus.out_mispredict  = out_mis_q;
   assign bus.out_redirect_pc = out_taken_q ? out_target_q : out_link_q;

   // Saturating counter step for the entry of the branch being accepted.
   always_comb begin
      bht_idx = bus.in_pc[IDX+1:2];
      bht_cur = bht_q[bht_idx];
      bht_nxt = bht_cur;
      if (taken_c) begin
         if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'b01;
      end else begin
         if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'b01;
      end
      bht_we = accept && legal_cond_c;
   end

   // BHT storage; every counter starts weakly not-taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else if (bht_we) begin
         bht_q[bht_idx] <= bht_nxt;
      end
   end

   // Fetch sees the registered table only; no bypass of an in-flight update.
   assign bus.pred_taken = bht_q[bus.pred_pc[IDX+1:2]][1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   branch_resolve_unit_if #(.XLEN(32)) bus();

   branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  kind;
      logic [2:0]  funct;
      logic [31:0] pc;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] imm;
      logic        pt;
      logic [31:0] ptg;
      logic        e_taken;
      logic [31:0] e_target;
      logic        e_mis;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(logic [1:0] kind, logic [2:0] funct, logic [31:0] pc,
                               logic [31:0] s1, logic [31:0] s2, logic [31:0] imm,
                               logic pt, logic [31:0] ptg,
                               logic et, logic [31:0] etg, logic em);
      vec_t v;
      v.kind = kind; v.funct = funct; v.pc = pc; v.src1 = s1; v.src2 = s2; v.imm = imm;
      v.pt = pt; v.ptg = ptg; v.e_taken = et; v.e_target = etg; v.e_mis = em;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.in_kind        = v.kind;
      bus.in_funct       = v.funct;
      bus.in_pc          = v.pc;
      bus.in_src1        = v.src1;
      bus.in_src2        = v.src2;
      bus.in_imm         = v.imm;
      bus.in_pred_taken  = v.pt;
      bus.in_pred_target = v.ptg;
   endtask

   // One accepted request with out_ready=1, result checked one cycle later.
   task automatic apply(input vec_t v, input string tag);
      logic [31:0] link;
      @(negedge clk);
      drive(v);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      link = v.pc + 32'd4;
      check({tag, " valid"},      64'(bus.out_valid), 64'd1);
      check({tag, " taken"},      64'(bus.out_taken), 64'(v.e_taken));
      check({tag, " target"},     64'(bus.out_target), 64'(v.e_target));
      check({tag, " mispredict"}, 64'(bus.out_mispredict), 64'(v.e_mis));
      check({tag, " link"},       64'(bus.out_link), 64'(link));
      check({tag, " redirect"},   64'(bus.out_redirect_pc),
            64'(v.e_taken ? v.e_target : link));
   endtask

   task automatic check_pred(input logic [31:0] pc, input logic exp, input string tag);
      bus.pred_pc = pc;
      #1;
      check(tag, 64'(bus.pred_taken), 64'(exp));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.in_kind = 2'b11; bus.in_funct = 3'b000; bus.in_pc = '0; bus.in_src1 = '0;
      bus.in_src2 = '0; bus.in_imm = '0; bus.in_pred_taken = 1'b0; bus.in_pred_target = '0;
      bus.pred_pc = 32'h40;

      //           kind   funct   pc            src1          src2          imm           pt  ptg           taken tgt           mis
      vecs[0]  = mk(2'b00, 3'b000, 32'h100,      32'd5,        32'd5,        32'h20,       0, 32'h0,        1, 32'h120,      1);
      vecs[1]  = mk(2'b00, 3'b001, 32'h104,      32'd5,        32'd5,        32'h20,       0, 32'h0,        0, 32'h124,      0);
      vecs[2]  = mk(2'b00, 3'b100, 32'h108,      32'hFFFFFFFF, 32'd1,        32'hFFFFFFF8, 1, 32'h100,      1, 32'h100,      0);
      vecs[3]  = mk(2'b00, 3'b110, 32'h10C,      32'hFFFFFFFF, 32'd1,        32'h8,        1, 32'h114,      0, 32'h114,      1);
      vecs[4]  = mk(2'b00, 3'b101, 32'h110,      32'h80000000, 32'h7FFFFFFF, 32'h10,       0, 32'h0,        0, 32'h120,      0);
      vecs[5]  = mk(2'b00, 3'b111, 32'h114,      32'h80000000, 32'h7FFFFFFF, 32'h10,       1, 32'h128,      1, 32'h124,      1);
      vecs[6]  = mk(2'b00, 3'b010, 32'h118,      32'd5,        32'd5,        32'h4,        0, 32'h0,        0, 32'h11C,      0);
      vecs[7]  = mk(2'b01, 3'b000, 32'h200,      32'd0,        32'd0,        32'h400,      1, 32'h600,      1, 32'h600,      0);
      vecs[8]  = mk(2'b10, 3'b000, 32'h300,      32'h1001,     32'd0,        32'h4,        1, 32'h1004,     1, 32'h1004,     0);
      vecs[9]  = mk(2'b10, 3'b000, 32'h300,      32'h1001,     32'd0,        32'h4,        1, 32'h1008,     1, 32'h1004,     1);
      vecs[10] = mk(2'b11, 3'b000, 32'h400,      32'd1,        32'd1,        32'h40,       0, 32'h0,        0, 32'h0,        0);
      vecs[11] = mk(2'b11, 3'b000, 32'h400,      32'd1,        32'd1,        32'h40,       1, 32'h0,        0, 32'h0,        1);
      vecs[12] = mk(2'b00, 3'b101, 32'h120,      32'd7,        32'd7,        32'h40,       1, 32'h160,      1, 32'h160,      0);
      vecs[13] = mk(2'b00, 3'b100, 32'hFFFFFFF0, 32'd1,        32'd2,        32'h20,       0, 32'h0,        1, 32'h10,       1);

      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid",  64'(bus.out_valid), 64'd0);
      check("reset out_target", 64'(bus.out_target), 64'd0);
      check("reset out_link",   64'(bus.out_link), 64'd0);
      check("reset redirect",   64'(bus.out_redirect_pc), 64'd0);
      check("reset mispredict", 64'(bus.out_mispredict), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset in_ready", 64'(bus.in_ready), 64'd1);
      check_pred(32'h40, 1'b0, "reset pred 0x40");

      // BHT training at 0x40: 01->10->11->11, then two not-taken 11->10->01.
      for (int i = 0; i < 3; i++) begin
         apply(mk(2'b00, 3'b000, 32'h40, 32'd5, 32'd5, 32'h10, 0, 32'h0, 1, 32'h50, 1), "beq40 taken");
         check_pred(32'h40, 1'b1, "bht taken pred");
      end
      apply(mk(2'b00, 3'b000, 32'h40, 32'd5, 32'd6, 32'h10, 0, 32'h0, 0, 32'h50, 0), "beq40 nt1");
      check_pred(32'h40, 1'b1, "bht saturated 11->10");
      apply(mk(2'b00, 3'b000, 32'h40, 32'd5, 32'd6, 32'h10, 0, 32'h0, 0, 32'h50, 0), "beq40 nt2");
      check_pred(32'h40, 1'b0, "bht 10->01");

      for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check("drain out_valid", 64'(bus.out_valid), 64'd0);

      // Stall: held result stays put while a new request waits.
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(vecs[7]);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("stall first valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      drive(mk(2'b00, 3'b000, 32'h80, 32'd1, 32'd1, 32'h8, 0, 32'h0, 1, 32'h88, 1));
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("stall in_ready", 64'(bus.in_ready), 64'd0);
         check("stall out_valid", 64'(bus.out_valid), 64'd1);
         check("stall out_target", 64'(bus.out_target), 64'h600);
         check("stall out_link", 64'(bus.out_link), 64'h204);
      end
      check_pred(32'h80, 1'b0, "stall no bht update");
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      check("release in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      check("release out_valid", 64'(bus.out_valid), 64'd1);
      check("release out_target", 64'(bus.out_target), 64'h88);
      check("release out_link", 64'(bus.out_link), 64'h84);
      check_pred(32'h80, 1'b1, "release bht update");
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("release drain", 64'(bus.out_valid), 64'd0);

      // Flush during a stall: result dropped, waiting request not accepted.
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(mk(2'b00, 3'b000, 32'hC0, 32'd1, 32'd1, 32'h4, 0, 32'h0, 1, 32'hC4, 1));
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("flush pre valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      drive(mk(2'b00, 3'b000, 32'hC4, 32'd1, 32'd1, 32'h4, 0, 32'h0, 1, 32'hC8, 1));
      @(posedge clk);
      #1;
      check("flush stall in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      bus.flush = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check("flush in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("flush out_valid", 64'(bus.out_valid), 64'd0);
      check_pred(32'hC4, 1'b0, "flush no bht update");
      check_pred(32'hC0, 1'b1, "flush earlier update kept");
      @(negedge clk);
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;

      // Async reset in the middle of a stall.
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(mk(2'b00, 3'b000, 32'h80, 32'd1, 32'd1, 32'h8, 1, 32'h88, 1, 32'h88, 0));
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("rst pre valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst out_target", 64'(bus.out_target), 64'd0);
      check("rst out_taken", 64'(bus.out_taken), 64'd0);
      check("rst out_link", 64'(bus.out_link), 64'd0);
      for (int e = 0; e < 64; e++) check_pred(32'(e) << 2, 1'b0, $sformatf("rst bht %0d", e));
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      apply(mk(2'b00, 3'b000, 32'h80, 32'd1, 32'd1, 32'h8, 1, 32'h88, 1, 32'h88, 0), "post rst beq");
      check_pred(32'h80, 1'b1, "post rst counter was 01");
      check_pred(32'hC0, 1'b0, "post rst other entry");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
